// File: rtl/fpga_spi_pkg.sv
// Shared definitions for the FPGA register-interface SPI initiator.
// Frame layout (MSB first): {addr[7:2], 1'b0, wr, data[15:0]}.
package fpga_spi_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2,
        StGap   = 2'd3
    } spi_state_e;

    localparam int unsigned FRAME_BITS  = 24;
    localparam int unsigned CMD_BITS    = 8;
    localparam int unsigned DATA_BITS   = 16;
    localparam int unsigned WR_FLAG_POS = 16;
    localparam int unsigned BIT_CNT_W   = 5;

    // Register byte addresses decoded by the FPGA register slave.
    localparam logic [7:0] ADDR_VERSION     = 8'h04;
    localparam logic [7:0] ADDR_REG_08      = 8'h08;
    localparam logic [7:0] ADDR_REG_0C      = 8'h0C;
    localparam logic [7:0] ADDR_REG_18      = 8'h18;
    localparam logic [7:0] ADDR_REG_38      = 8'h38;
    localparam logic [7:0] ADDR_SSHIGHDELAY = 8'h3C;
    localparam logic [7:0] ADDR_LAMPENABLE  = 8'h40;
    localparam logic [7:0] ADDR_REG_5C      = 8'h5C;
    localparam logic [7:0] ADDR_REG_68      = 8'h68;

    // Reads carry zero data; address bits [1:0] are dropped.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 wr,
        input logic [CMD_BITS-1:0]  addr,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [DATA_BITS-1:0] data;
        data = wr ? wdata : '0;
        return {addr[CMD_BITS-1:2], 1'b0, wr, data};
    endfunction

endpackage

// File: rtl/fpga_spi_master_sclk_gen.sv
// SCLK half-period generator.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   en       : counter runs while high; when low, counter clears and sclk is forced low
//   stop     : suppresses the rising edge that would follow the current low half
//   sclk     : generated serial clock level
//   rise     : last cycle of a low half (sclk rises next cycle unless stopped)
//   fall     : last cycle of a high half (sclk falls next cycle)
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic stop,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             half_end;

    always_comb begin
        half_end = en && (cnt_q == CNT_MAX);
        rise     = half_end && !sclk_q;
        fall     = half_end && sclk_q;
        cnt_d    = (en && !half_end) ? cnt_q + CNT_W'(1) : '0;
        sclk_d   = sclk_q;
        if (!en) begin
            sclk_d = 1'b0;
        end else if (rise && !stop) begin
            sclk_d = 1'b1;
        end else if (fall) begin
            sclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/fpga_spi_master.sv
// SPI mode-0 initiator issuing 24-bit register read/write frames.
// Ports:
//   sys_clk, sys_rst     : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only when idle)
//   cmd_wr, cmd_addr, cmd_wdata : command fields, latched on accept
//   rsp_valid, rsp_rdata : one-cycle response pulse, data held until next pulse
//   busy                 : transfer in progress
//   spi_clk, spi_cs, spi_mosi, spi_miso : SPI bus (cs active low)
module fpga_spi_master
    import fpga_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_wr,
    input  logic [CMD_BITS-1:0]  cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 spi_clk,
    output logic                 spi_cs,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("fpga_spi_master: CLK_DIV must be at least 4");
    end

    localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] FIRST_RX_BIT = BIT_CNT_W'(CMD_BITS);

    spi_state_e state_q, state_d;

    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic [DATA_BITS-1:0]  rx_q, rx_d;
    logic [DATA_BITS-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  miso_meta_q, miso_sync_q;
    logic                  accept;
    logic                  sclk_en, sclk_stop, rise, fall;

    assign accept = cmd_valid && (state_q == StIdle);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .en   (sclk_en),
        .stop (sclk_stop),
        .sclk (spi_clk),
        .rise (rise),
        .fall (fall)
    );

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. SETUP and GAP are timed as SCLK low halves, so the rise
    // tick marks their end as well as the end of each SHIFT period.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StSetup;
            StSetup: if (rise) state_d = StShift;
            StShift: if (rise && (bit_cnt_q == LAST_BIT)) state_d = StGap;
            StGap:   if (rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        spi_cs    = (state_q == StIdle) || (state_q == StGap);
        sclk_en   = (state_q != StIdle);
        // No rising edge after period 24 nor during GAP.
        sclk_stop = (state_q == StGap) ||
                    ((state_q == StShift) && (bit_cnt_q == LAST_BIT));
    end

    // Datapath next state.
    always_comb begin
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        rsp_valid_d = (state_q == StShift) && rise && (bit_cnt_q == LAST_BIT);
        rsp_rdata_d = rsp_valid_d ? rx_q : rsp_rdata_q;

        // Shifting in zeros leaves MOSI low once the frame is out.
        if (accept) begin
            tx_d = build_frame(cmd_wr, cmd_addr, cmd_wdata);
        end else if (fall) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end

        // Only the 16 data periods carry slave read data.
        if (fall && (bit_cnt_q >= FIRST_RX_BIT)) begin
            rx_d = {rx_q[DATA_BITS-2:0], miso_sync_q};
        end

        if (state_q != StShift) begin
            bit_cnt_d = '0;
        end else if (rise) begin
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            miso_meta_q <= spi_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign spi_mosi  = tx_q[FRAME_BITS-1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/fpga_spi_master.md
# fpga_spi_master

SPI initiator for the FPGA register interface: it issues the 24-bit read/write frames that the FPGA register slave decodes (8-bit command, 16-bit data, mode 0, MSB first). It takes one command at a time over a valid/ready handshake, generates SCLK/CS/MOSI from `sys_clk`, captures the 16-bit MISO word and returns it as a single-cycle response. It is used as the bench/bring-up master and as the on-board controller when one FPGA configures another.

## Interface
- `CLK_DIV`, 4: `sys_clk` cycles per SCLK half-period; legal range ≥ 4. Smaller values are illegal and must fail elaboration.
- `sys_clk`  in  1  system clock; the only clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; transfer on `cmd_valid && cmd_ready`.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  8  register byte address; bits [1:0] ignored.
- `cmd_wdata`  in  16  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse at end of frame.
- `rsp_rdata`  out  16  word captured from MISO; held until next `rsp_valid`.
- `busy`  out  1  high from accept until `cmd_ready` reasserts.
- `spi_clk`  out  1  SCLK, idles low.
- `spi_cs`  out  1  chip select, active low, idles high.
- `spi_mosi`  out  1  serial data to slave.
- `spi_miso`  in  1  serial data from slave (asynchronous to `sys_clk`).

## Operation
- Frame (24 bits, MSB first): `{cmd_addr[7:2], 1'b0, cmd_wr, data[15:0]}`; data = `cmd_wdata` for writes, 16'h0000 for reads.
- All command fields are latched on accept; inputs may change afterwards.
- FSM: IDLE → SETUP → SHIFT → GAP → IDLE.
  - IDLE: `cmd_ready`=1, `spi_cs`=1, `spi_clk`=0. On accept → SETUP.
  - SETUP: `spi_cs`=0, `spi_mosi`=frame bit 23, `CLK_DIV` cycles → SHIFT.
  - SHIFT: 24 SCLK periods, each consisting of a high half then a low half of `CLK_DIV` cycles.
    - MOSI changes only in the cycle SCLK falls (mode 0).
    - MISO is sampled in the last `sys_clk` cycle of high halves 9..24 and shifted into `rsp_rdata` MSB first.
    - The low half of period 24 serves as CS hold time.
  - GAP: `spi_cs`=1 for `CLK_DIV` cycles, long enough for the slave to detect the CS rising edge. `rsp_valid` pulses in the first GAP cycle. → IDLE.
- `spi_miso` passes through a 2-flop synchronizer before sampling.
- On writes, `rsp_rdata` returns the value the slave shifts out during the write, which is the register content before the write.
- `cmd_valid` while busy: not accepted. The requester holds the command.

## Timing
- Reset values: `cmd_ready`=1, `busy`=0, `spi_cs`=1, `spi_clk`=0, `spi_mosi`=0, `rsp_valid`=0, `rsp_rdata`=16'h0000. The FSM resets to IDLE and all counters to 0.
- Accept at cycle T:
  - `spi_cs` falls at T+1.
  - First SCLK rise at T+1+`CLK_DIV`.
  - `spi_cs` is low for exactly 49·`CLK_DIV` cycles.
  - `rsp_valid` at T+1+49·`CLK_DIV`.
  - `cmd_ready` at T+1+50·`CLK_DIV`.
- Default `CLK_DIV`=4: 196 cycles of CS low, 201 cycles accept-to-ready.
- SCLK has exactly 24 rising edges per frame; no SCLK edge occurs while `spi_cs`=1.
- Back-to-back: a command held on `cmd_valid` is accepted in the first ready cycle, so minimum CS-high time is `CLK_DIV`+1 cycles.
- `sys_rst` mid-frame: outputs return to reset values immediately (asynchronously). `rsp_valid` is not issued. Because the slave sees fewer than 24 bits, no write is committed.

## Structure
- Package `fpga_spi_pkg`:
  - FSM state enum.
  - `FRAME_BITS`=24, `CMD_BITS`=8, `DATA_BITS`=16, `WR_FLAG_POS`=16.
  - Register address constants (0x04, 0x08, 0x0C, 0x18, 0x38, 0x3C, 0x40, 0x5C, 0x68), shared with the slave.
- Sub-module `spi_sclk_gen`: half-period counter that produces a rise tick and a fall tick. The FSM, bit counter (0..23) and shift registers stay in the top module.

## Test plan
Unless stated otherwise, the DUT drives the FPGA register slave, and the slave is reset with the DUT.
- Read 0x04 after reset → MOSI frame 0x040000, `rsp_rdata`=16'h0001, `rsp_valid` one cycle at T+197 (`CLK_DIV`=4).
- Write 0x18=0x1234 → MOSI 0x191234, `rsp_rdata`=16'd600 (0x0258). A subsequent read of 0x18 → 0x1234.
- Write 0x40=0x0001 with `cmd_addr`=0x43 → frame 0x410001, slave LAMPENABLE=1.
- Two commands with `cmd_valid` held continuously → second accepted exactly at first `cmd_ready` rise. Verify no command is dropped, CS-high time = 5 cycles, and no SCLK edge occurs with CS high.
- `sys_rst` pulsed after the 12th SCLK rise of write 0x3C=0xBEEF → CS high immediately, no `rsp_valid`, slave SSHIGHDELAY unchanged (0x0001).
- Protocol monitor over 200 random commands (`CLK_DIV`=4 and 7) → MOSI stable across every rising edge, exactly 24 rises per frame, `rsp_rdata` matches a reference register model.
